// File: rtl/gat_spmm_pkg.sv
// Shared constants, node_info field layout and feeder FSM encoding for the
// sparse PE datapath.
package gat_spmm_pkg;

  // Width of one nonzero value and of the PE result.
  localparam int DATA_WIDTH       = 8;
  // Number of slots in one PE row vector (max nonzeros per row).
  localparam int DOT_PRODUCT_SIZE = 5;
  // Width of one column index inside a row vector.
  localparam int COL_IDX_WIDTH    = $clog2(DOT_PRODUCT_SIZE);
  // node_info = {count, flag}.
  localparam int NODE_INFO_WIDTH  = $clog2(DOT_PRODUCT_SIZE) + 1;
  // Width of the nonzero count field (also the slot counter width).
  localparam int COUNT_WIDTH      = NODE_INFO_WIDTH - 1;

  // node_info field positions.
  localparam int NI_FLAG_BIT      = 0;
  localparam int NI_COUNT_LSB     = 1;
  localparam int NI_COUNT_MSB     = NODE_INFO_WIDTH - 1;

  // Feeder FSM states.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT_PE = 2'd2,
    OUTPUT  = 2'd3
  } feeder_state_e;

  // Builds the node_info word from a nonzero count and the row flag.
  function automatic logic [NODE_INFO_WIDTH-1:0] pack_node_info(
    input logic [COUNT_WIDTH-1:0] count,
    input logic                   flag
  );
    logic [NODE_INFO_WIDTH-1:0] word;
    word                              = '0;
    word[NI_COUNT_MSB:NI_COUNT_LSB]   = count;
    word[NI_FLAG_BIT]                 = flag;
    return word;
  endfunction

endpackage

// File: rtl/sp_pe_row_feeder_if.sv
// Bundle of the nonzero stream, PE issue/result and result-output signals
// around the row feeder. The master modport is the feeder itself; the slave
// modport is everything around it (stream source, PE, downstream sink).
interface sp_pe_row_feeder_if #(
  parameter int ROW_IDX_WIDTH = 4
);
  import gat_spmm_pkg::*;

  // Nonzero stream (CSR order, one row at a time).
  logic                                          nz_valid_i;
  logic                                          nz_ready_o;
  logic [COL_IDX_WIDTH-1:0]                      nz_col_idx_i;
  logic [DATA_WIDTH-1:0]                         nz_value_i;
  logic                                          nz_last_i;
  logic                                          nz_empty_i;
  logic                                          row_flag_i;

  // PE issue side.
  logic                                          pe_valid_o;
  logic [DOT_PRODUCT_SIZE-1:0][COL_IDX_WIDTH-1:0] pe_col_idx_o;
  logic [DOT_PRODUCT_SIZE-1:0][DATA_WIDTH-1:0]   pe_value_o;
  logic [NODE_INFO_WIDTH-1:0]                    pe_node_info_o;

  // PE result side.
  logic                                          pe_ready_i;
  logic [DATA_WIDTH-1:0]                         pe_result_i;

  // Downstream result channel and status.
  logic                                          res_valid_o;
  logic                                          res_ready_i;
  logic [DATA_WIDTH-1:0]                         res_data_o;
  logic [ROW_IDX_WIDTH-1:0]                      res_row_idx_o;
  logic                                          matrix_done_o;
  logic                                          err_overflow_o;

  modport master (
    input  nz_valid_i, nz_col_idx_i, nz_value_i, nz_last_i, nz_empty_i, row_flag_i,
    output nz_ready_o,
    output pe_valid_o, pe_col_idx_o, pe_value_o, pe_node_info_o,
    input  pe_ready_i, pe_result_i,
    output res_valid_o, res_data_o, res_row_idx_o, matrix_done_o, err_overflow_o,
    input  res_ready_i
  );

  modport slave (
    output nz_valid_i, nz_col_idx_i, nz_value_i, nz_last_i, nz_empty_i, row_flag_i,
    input  nz_ready_o,
    input  pe_valid_o, pe_col_idx_o, pe_value_o, pe_node_info_o,
    output pe_ready_i, pe_result_i,
    input  res_valid_o, res_data_o, res_row_idx_o, matrix_done_o, err_overflow_o,
    output res_ready_i
  );

endinterface

// File: rtl/sp_pe_row_feeder.sv
// Row feeder for the sparse PE: packs one CSR row of nonzeros into the PE's
// parallel slot vectors, fires a single issue pulse, waits for the PE reply
// and hands the result downstream tagged with its row index. Only one row is
// ever in flight. Weight columns reach the PE from the weight buffer.
module sp_pe_row_feeder
  import gat_spmm_pkg::*;
#(
  parameter int NUM_ROWS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sp_pe_row_feeder_if.master   bus
);

  localparam int                       ROW_IDX_WIDTH = $clog2(NUM_ROWS);
  localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX     = COUNT_WIDTH'(DOT_PRODUCT_SIZE);
  localparam logic [ROW_IDX_WIDTH-1:0] ROW_LAST      = ROW_IDX_WIDTH'(NUM_ROWS - 1);

  feeder_state_e state_r;
  feeder_state_e state_s;

  // Slot storage being filled for the current row.
  logic [DOT_PRODUCT_SIZE-1:0][COL_IDX_WIDTH-1:0] slot_col_r;
  logic [DOT_PRODUCT_SIZE-1:0][COL_IDX_WIDTH-1:0] slot_col_s;
  logic [DOT_PRODUCT_SIZE-1:0][DATA_WIDTH-1:0]    slot_val_r;
  logic [DOT_PRODUCT_SIZE-1:0][DATA_WIDTH-1:0]    slot_val_s;
  logic [COUNT_WIDTH-1:0]                         count_r;
  logic [COUNT_WIDTH-1:0]                         count_s;
  logic                                           flag_r;
  logic                                           flag_s;
  logic                                           err_r;
  logic                                           err_s;

  // Registered PE-facing copies, held while the PE works on the row.
  logic                                           pe_valid_r;
  logic [DOT_PRODUCT_SIZE-1:0][COL_IDX_WIDTH-1:0] pe_col_r;
  logic [DOT_PRODUCT_SIZE-1:0][DATA_WIDTH-1:0]    pe_val_r;
  logic [NODE_INFO_WIDTH-1:0]                     pe_ni_r;

  // Result channel.
  logic                                           nz_ready_r;
  logic                                           res_valid_r;
  logic [DATA_WIDTH-1:0]                          res_data_r;
  logic [ROW_IDX_WIDTH-1:0]                       row_idx_r;

  logic nz_fire_s;
  logic res_fire_s;
  logic issue_load_s;
  logic pe_capture_s;

  assign nz_fire_s    = nz_ready_r & bus.nz_valid_i;
  assign res_fire_s   = res_valid_r & bus.res_ready_i;
  // The PE vectors are loaded on the edge that accepts the row's last beat.
  assign issue_load_s = (state_r == COLLECT) && (state_s == ISSUE);
  // A PE reply only counts while a row is actually outstanding.
  assign pe_capture_s = (state_r == WAIT_PE) && bus.pe_ready_i;

  // Next-state and slot-update logic for the row collection FSM.
  always_comb begin
    state_s    = state_r;
    slot_col_s = slot_col_r;
    slot_val_s = slot_val_r;
    count_s    = count_r;
    flag_s     = flag_r;
    err_s      = err_r;
    case (state_r)
      COLLECT: begin
        if (nz_fire_s) begin
          if (bus.nz_empty_i) begin
            // Empty-row marker beat: no slot is consumed.
            count_s = count_r;
          end else if (count_r == COUNT_MAX) begin
            // Row wider than the PE: beat is swallowed, error latched.
            err_s = 1'b1;
          end else begin
            for (int i = 0; i < DOT_PRODUCT_SIZE; i++) begin
              if (count_r == COUNT_WIDTH'(i)) begin
                slot_col_s[i] = bus.nz_col_idx_i;
                slot_val_s[i] = bus.nz_value_i;
              end else begin
                slot_col_s[i] = slot_col_r[i];
                slot_val_s[i] = slot_val_r[i];
              end
            end
            count_s = count_r + COUNT_WIDTH'(1);
          end
          if (bus.nz_last_i) begin
            flag_s  = bus.row_flag_i;
            state_s = ISSUE;
          end else begin
            state_s = COLLECT;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      ISSUE: begin
        state_s = WAIT_PE;
      end
      WAIT_PE: begin
        if (bus.pe_ready_i) begin
          state_s = OUTPUT;
        end else begin
          state_s = WAIT_PE;
        end
      end
      OUTPUT: begin
        if (res_fire_s) begin
          // Row retired: empty the slots so unused entries read as zero.
          slot_col_s = '0;
          slot_val_s = '0;
          count_s    = '0;
          flag_s     = 1'b0;
          state_s    = COLLECT;
        end else begin
          state_s = OUTPUT;
        end
      end
      default: begin
        state_s = COLLECT;
      end
    endcase
  end

  // FSM state, slot storage, count and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= COLLECT;
      slot_col_r <= '0;
      slot_val_r <= '0;
      count_r    <= '0;
      flag_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      slot_col_r <= slot_col_s;
      slot_val_r <= slot_val_s;
      count_r    <= count_s;
      flag_r     <= flag_s;
      err_r      <= err_s;
    end
  end

  // Handshake strobes, decoded one cycle ahead so they leave a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_ready_r  <= 1'b0;
      pe_valid_r  <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      nz_ready_r  <= (state_s == COLLECT);
      pe_valid_r  <= (state_s == ISSUE);
      res_valid_r <= (state_s == OUTPUT);
    end
  end

  // PE row vectors and node_info, frozen from issue until the next row loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_col_r <= '0;
      pe_val_r <= '0;
      pe_ni_r  <= '0;
    end else if (issue_load_s) begin
      pe_col_r <= slot_col_s;
      pe_val_r <= slot_val_s;
      pe_ni_r  <= pack_node_info(count_s, flag_s);
    end else begin
      pe_col_r <= pe_col_r;
      pe_val_r <= pe_val_r;
      pe_ni_r  <= pe_ni_r;
    end
  end

  // Captures the PE result for the outstanding row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_r <= '0;
    end else if (pe_capture_s) begin
      res_data_r <= bus.pe_result_i;
    end else begin
      res_data_r <= res_data_r;
    end
  end

  // Row index advances on every accepted result and wraps at the matrix end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx_r <= '0;
    end else if (res_fire_s) begin
      if (row_idx_r == ROW_LAST) begin
        row_idx_r <= '0;
      end else begin
        row_idx_r <= row_idx_r + ROW_IDX_WIDTH'(1);
      end
    end else begin
      row_idx_r <= row_idx_r;
    end
  end

  assign bus.nz_ready_o     = nz_ready_r;
  assign bus.pe_valid_o     = pe_valid_r;
  assign bus.pe_col_idx_o   = pe_col_r;
  assign bus.pe_value_o     = pe_val_r;
  assign bus.pe_node_info_o = pe_ni_r;
  assign bus.res_valid_o    = res_valid_r;
  assign bus.res_data_o     = res_data_r;
  assign bus.res_row_idx_o  = row_idx_r;
  assign bus.err_overflow_o = err_r;
  // Pulses in the very cycle the last row of the matrix is handed off.
  assign bus.matrix_done_o  = res_fire_s & (row_idx_r == ROW_LAST);

endmodule

// File: tb/tb_sp_pe_row_feeder.sv
// Bench for sp_pe_row_feeder: directed and randomized rows, a PE stub that
// answers with the sum of the row values three cycles after issue, and a
// row-level reference model (first DOT_PRODUCT_SIZE real beats are packed,
// extra beats set a sticky error, row index counts accepted results mod NR).
module tb_sp_pe_row_feeder;
  import gat_spmm_pkg::*;

  localparam int NR = 4;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sp_pe_row_feeder_if #(.ROW_IDX_WIDTH(RW)) bus ();

  sp_pe_row_feeder #(.NUM_ROWS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   passed = 0;
  int   total  = 0;
  int   failed = 0;
  int   pe_pulses   = 0;
  int   rows_issued = 0;
  int   exp_row     = 0;
  logic err_exp     = 1'b0;

  // Current row description.
  int                       nb;
  logic [COL_IDX_WIDTH-1:0] bcol [8];
  logic [DATA_WIDTH-1:0]    bval [8];
  logic                     bempty;
  logic                     bflag;

  // Counts issue pulses seen on the PE interface.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pe_valid_o === 1'b1) pe_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nz_ready"},   64'(bus.nz_ready_o),     64'd0);
    chk({tag, "_pe_valid"},   64'(bus.pe_valid_o),     64'd0);
    chk({tag, "_pe_col"},     64'(bus.pe_col_idx_o),   64'd0);
    chk({tag, "_pe_value"},   64'(bus.pe_value_o),     64'd0);
    chk({tag, "_node_info"},  64'(bus.pe_node_info_o), 64'd0);
    chk({tag, "_res_valid"},  64'(bus.res_valid_o),    64'd0);
    chk({tag, "_res_data"},   64'(bus.res_data_o),     64'd0);
    chk({tag, "_row_idx"},    64'(bus.res_row_idx_o),  64'd0);
    chk({tag, "_mdone"},      64'(bus.matrix_done_o),  64'd0);
    chk({tag, "_err"},        64'(bus.err_overflow_o), 64'd0);
  endtask

  task automatic set_random_row();
    bempty = ($urandom_range(0, 7) == 0);
    nb     = bempty ? 1 : int'($urandom_range(1, 7));
    bflag  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin
      bcol[i] = COL_IDX_WIDTH'($urandom_range(0, DOT_PRODUCT_SIZE - 1));
      bval[i] = DATA_WIDTH'($urandom);
    end
  endtask

  // Sends the current row, plays the PE, and checks the result handoff.
  task automatic do_row(input int hold, input bit do_reset);
    logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] ecol;
    logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    evalv;
    logic [DATA_WIDTH-1:0]                     esum;
    logic [NODE_INFO_WIDTH-1:0]                eni;
    int ecnt;
    int tries;
    // Reference model for this row.
    ecnt  = 0;
    ecol  = '0;
    evalv = '0;
    esum  = '0;
    if (!bempty) begin
      for (int i = 0; i < nb; i++) begin
        if (ecnt < DOT_PRODUCT_SIZE) begin
          ecol[ecnt*COL_IDX_WIDTH +: COL_IDX_WIDTH] = bcol[i];
          evalv[ecnt*DATA_WIDTH +: DATA_WIDTH]      = bval[i];
          esum = esum + bval[i];
          ecnt++;
        end else begin
          err_exp = 1'b1;
        end
      end
    end
    eni = {ecnt[NODE_INFO_WIDTH-2:0], bflag};
    // Stream the beats, with occasional idle gaps.
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.nz_valid_i   = 1'b0;
        bus.nz_col_idx_i = COL_IDX_WIDTH'($urandom);
        bus.nz_value_i   = DATA_WIDTH'($urandom);
        step();
      end
      bus.nz_valid_i   = 1'b1;
      bus.nz_col_idx_i = bempty ? COL_IDX_WIDTH'($urandom) : bcol[i];
      bus.nz_value_i   = bempty ? DATA_WIDTH'($urandom) : bval[i];
      bus.nz_last_i    = (i == nb - 1);
      bus.nz_empty_i   = bempty;
      bus.row_flag_i   = (i == nb - 1) ? bflag : 1'($urandom_range(0, 1));
      tries = 0;
      while (bus.nz_ready_o !== 1'b1 && tries < 40) begin
        step();
        tries++;
      end
      chk("nz_ready_beat", 64'(bus.nz_ready_o), 64'd1);
      step();
    end
    bus.nz_valid_i = 1'b0;
    bus.nz_last_i  = 1'b0;
    bus.nz_empty_i = 1'b0;
    bus.row_flag_i = 1'b0;
    // Issue cycle: one cycle after the last beat.
    chk("pe_valid_issue", 64'(bus.pe_valid_o),     64'd1);
    chk("nz_ready_issue", 64'(bus.nz_ready_o),     64'd0);
    chk("pe_col",         64'(bus.pe_col_idx_o),   64'(ecol));
    chk("pe_value",       64'(bus.pe_value_o),     64'(evalv));
    chk("node_info",      64'(bus.pe_node_info_o), 64'(eni));
    chk("err_overflow",   64'(bus.err_overflow_o), 64'(err_exp));
    rows_issued++;
    step();
    chk("pe_valid_pulse", 64'(bus.pe_valid_o), 64'd0);
    if (do_reset) begin
      step();
      rst = 1'b1;
      #1;
      chk_all_zero("rst_wait_pe");
      step();
      step();
      rst = 1'b0;
      step();
      // Late reply from the PE for the discarded row.
      bus.pe_ready_i  = 1'b1;
      bus.pe_result_i = 8'h55;
      step();
      bus.pe_ready_i  = 1'b0;
      chk("late_ready_res_valid", 64'(bus.res_valid_o), 64'd0);
      step();
      chk("late_ready_res_valid2", 64'(bus.res_valid_o), 64'd0);
      chk("post_rst_nz_ready",     64'(bus.nz_ready_o),  64'd1);
      chk("post_rst_res_data",     64'(bus.res_data_o),  64'd0);
      exp_row = 0;
      err_exp = 1'b0;
    end else begin
      step();
      chk("res_valid_early", 64'(bus.res_valid_o), 64'd0);
      step();
      bus.pe_ready_i  = 1'b1;
      bus.pe_result_i = esum;
      step();
      bus.pe_ready_i  = 1'b0;
      bus.pe_result_i = DATA_WIDTH'($urandom);
      chk("res_valid", 64'(bus.res_valid_o),   64'd1);
      chk("res_data",  64'(bus.res_data_o),    64'(esum));
      chk("row_idx",   64'(bus.res_row_idx_o), 64'(exp_row));
      for (int k = 0; k < hold; k++) begin
        bus.res_ready_i = 1'b0;
        step();
        chk("hold_res_valid", 64'(bus.res_valid_o),   64'd1);
        chk("hold_res_data",  64'(bus.res_data_o),    64'(esum));
        chk("hold_row_idx",   64'(bus.res_row_idx_o), 64'(exp_row));
        chk("hold_nz_ready",  64'(bus.nz_ready_o),    64'd0);
        chk("hold_pe_valid",  64'(bus.pe_valid_o),    64'd0);
      end
      bus.res_ready_i = 1'b1;
      #1;
      chk("matrix_done", 64'(bus.matrix_done_o), 64'(exp_row == NR - 1));
      step();
      bus.res_ready_i = 1'b0;
      chk("res_valid_drop",  64'(bus.res_valid_o),   64'd0);
      chk("nz_ready_return", 64'(bus.nz_ready_o),    64'd1);
      chk("matrix_done_end", 64'(bus.matrix_done_o), 64'd0);
      exp_row = (exp_row + 1) % NR;
    end
    chk("pe_pulse_count", 64'(pe_pulses), 64'(rows_issued));
    chk("err_sticky",     64'(bus.err_overflow_o), 64'(err_exp));
  endtask

  initial begin
    rst              = 1'b1;
    bus.nz_valid_i   = 1'b0;
    bus.nz_col_idx_i = '0;
    bus.nz_value_i   = '0;
    bus.nz_last_i    = 1'b0;
    bus.nz_empty_i   = 1'b0;
    bus.row_flag_i   = 1'b0;
    bus.pe_ready_i   = 1'b0;
    bus.pe_result_i  = '0;
    bus.res_ready_i  = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("nz_ready_after_rst", 64'(bus.nz_ready_o), 64'd1);

    // Three-beat row: (1,4) (3,2) (0,7 last), flag 1.
    nb = 3; bempty = 1'b0; bflag = 1'b1;
    bcol[0] = 3'd1; bval[0] = 8'd4;
    bcol[1] = 3'd3; bval[1] = 8'd2;
    bcol[2] = 3'd0; bval[2] = 8'd7;
    do_row(0, 1'b0);

    // All-zero row signalled by an empty-marker beat.
    nb = 1; bempty = 1'b1; bflag = 1'b0;
    do_row(2, 1'b0);

    // Seven beats into a five-slot row.
    set_random_row();
    nb = 7; bempty = 1'b0;
    do_row(1, 1'b0);

    // Downstream stalls for ten cycles; this is the last row of the matrix.
    set_random_row();
    nb = 4; bempty = 1'b0;
    do_row(10, 1'b0);

    // Row index wraps back to 0; overflow error is still set.
    set_random_row();
    nb = 2; bempty = 1'b0;
    do_row(0, 1'b0);

    // Reset while the PE is busy.
    set_random_row();
    nb = 3; bempty = 1'b0;
    do_row(0, 1'b1);

    // Randomized rows after reset.
    for (int r = 0; r < 10; r++) begin
      set_random_row();
      do_row(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
